// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

    localparam int N_BIT_DEF = 8;
    localparam int N_REQ_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESPOND
    } state_t;

    // Full signed product width for an n_bit x n_bit multiply.
    function automatic int prod_w(input int n_bit);
        return 2 * n_bit;
    endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Requester-side and multiplier-side bus of the shared Booth multiplier.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready accept handshake; rsp_valid has no backpressure.
//   slave  : arbiter view (requests and multiplier status in, grants/results/start out)
//   master : environment view (requesters plus multiplier instance)
interface booth_mul_arbiter_if
    import booth_pkg::*;
#(
    parameter int N_BIT = N_BIT_DEF,
    parameter int N_REQ = N_REQ_DEF
);
    localparam int PW = prod_w(N_BIT);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][N_BIT-1:0] req_a;
    logic [N_REQ-1:0][N_BIT-1:0] req_b;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [PW-1:0]               rsp_product;
    logic                        mul_Request;
    logic [N_BIT-1:0]            mul_M;
    logic [N_BIT-1:0]            mul_Q;
    logic                        mul_Done;
    logic [PW-1:0]               mul_Product;

    modport slave (
        input  req_valid, req_a, req_b, mul_Done, mul_Product,
        output req_ready, rsp_valid, rsp_product, mul_Request, mul_M, mul_Q
    );

    modport master (
        output req_valid, req_a, req_b, mul_Done, mul_Product,
        input  req_ready, rsp_valid, rsp_product, mul_Request, mul_M, mul_Q
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request strictly after i_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; o_any flags that o_idx is meaningful.
//   i_req : request vector   i_ptr : last granted index
//   o_idx : chosen index     o_any : any request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;

    // Lower half holds only requests above the pointer, upper half the full
    // vector; the lowest set bit of the doubled vector is the wrapped winner.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i > int'(i_ptr));
        end
        w_dbl = {i_req, i_req & w_mask};
        o_idx = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                o_idx = IW'(i % N);
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth multiplier between N_REQ requesters with round-robin grant.
// Latency: rsp_valid N_BIT+4 cycles after the IDLE sample for an N_BIT+1 cycle multiply.
// Backpressure: requests wait in req_valid until granted; results are never stalled.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io_bus       : requester handshake, results, multiplier start/operands/status
//   o_busy       : any state but IDLE    o_err : one-cycle start-timeout pulse
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter int N_BIT         = N_BIT_DEF,
    parameter int N_REQ         = N_REQ_DEF,
    parameter int START_TIMEOUT = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    booth_mul_arbiter_if.slave io_bus,
    output logic               o_busy,
    output logic               o_err
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = prod_w(N_BIT);
    localparam int CW = $clog2(START_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);

    state_t           r_state, w_next;
    logic [IW-1:0]    r_rr_ptr, r_g, w_pick;
    logic             w_any;
    logic [N_BIT-1:0] r_m, r_q;
    logic [PW-1:0]    r_prod;
    logic [CW-1:0]    r_cnt;
    logic             r_err;
    logic             w_timeout;
    logic [N_REQ-1:0] w_onehot;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .i_req (io_bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    // Done still high on the last allowed WAIT_BUSY cycle: multiplier never started.
    assign w_timeout = (r_state == WAIT_BUSY) && io_bus.mul_Done && (r_cnt == TO_LAST);
    assign w_onehot  = N_REQ'(1) << r_g;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (w_any) w_next = ISSUE;
            ISSUE:     w_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!io_bus.mul_Done) w_next = WAIT_DONE;
                else if (w_timeout)   w_next = IDLE;
            end
            WAIT_DONE: if (io_bus.mul_Done) w_next = RESPOND;
            RESPOND:   w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= IW'(N_REQ - 1);
            r_g      <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_g <= w_pick;
                        r_m <= io_bus.req_a[w_pick];
                        r_q <= io_bus.req_b[w_pick];
                    end
                end
                ISSUE: begin
                    r_rr_ptr <= r_g;
                    r_cnt    <= '0;
                end
                WAIT_BUSY: if (io_bus.mul_Done) r_cnt <= r_cnt + 1'b1;
                WAIT_DONE: if (io_bus.mul_Done) r_prod <= io_bus.mul_Product;
                default: ;
            endcase
        end
    end

    always_comb begin
        io_bus.req_ready   = '0;
        io_bus.rsp_valid   = '0;
        io_bus.mul_Request = 1'b0;
        case (r_state)
            ISSUE: begin
                io_bus.req_ready   = w_onehot;
                io_bus.mul_Request = 1'b1;
            end
            RESPOND: io_bus.rsp_valid = w_onehot;
            default: ;
        endcase
    end

    assign io_bus.mul_M       = r_m;
    assign io_bus.mul_Q       = r_q;
    assign io_bus.rsp_product = r_prod;
    assign o_busy             = (r_state != IDLE);
    assign o_err              = r_err;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: transaction-level model plus a multiplier model.
// Latency: n/a.
// Backpressure: n/a.
module tb_booth_mul_arbiter;
    localparam int NB   = 8;
    localparam int NR   = 4;
    localparam int TO   = 3;
    localparam int PW   = 2 * NB;
    localparam int LAT  = NB + 4;
    localparam int MAXC = 4096;

    logic clk;
    logic rst;
    logic busy;
    logic err;

    booth_mul_arbiter_if #(.N_BIT(NB), .N_REQ(NR)) bus ();

    booth_mul_arbiter #(.N_BIT(NB), .N_REQ(NR), .START_TIMEOUT(TO)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus),
        .o_busy (busy),
        .o_err  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Expected outputs per cycle, filled ahead of time by the model.
    bit [NR-1:0] e_rdy [MAXC];
    bit [NR-1:0] e_rsp [MAXC];
    bit [PW-1:0] e_prd [MAXC];
    bit          e_bsy [MAXC];
    bit          e_err [MAXC];

    int m_ptr = NR - 1;
    int m_idle_from = 0;
    bit m_stall_tx = 1'b0;
    bit force_stall = 1'b0;
    bit auto_rand = 1'b0;
    int mb_left = 0;
    logic [PW-1:0] mprod = '0;

    int rsp_cyc[$], rsp_idx[$], rsp_prd[$], rdy_cyc[$], err_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    endtask

    function automatic int qg(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int idx_of(input logic [NR-1:0] v);
        int r = -1;
        for (int i = NR - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Transaction model: decides from the inputs held during cycle p what the
    // arbiter must show in later cycles.
    task automatic model_step(input int p);
        int g;
        int pr;
        bit [NR-1:0] oh;
        if (rst) begin
            for (int k = p + 1; k < p + 40 && k < MAXC; k++) begin
                e_rdy[k] = '0; e_rsp[k] = '0; e_prd[k] = '0; e_bsy[k] = 0; e_err[k] = 0;
            end
            m_ptr = NR - 1;
            m_idle_from = p + 1;
            return;
        end
        if (p >= m_idle_from && bus.req_valid != '0) begin
            g = -1;
            for (int k = 1; k <= NR; k++)
                if (g < 0 && bus.req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            m_ptr = g;
            m_stall_tx = auto_rand ? ($urandom_range(0, 9) == 0) : force_stall;
            oh = '0;
            oh[g] = 1'b1;
            e_rdy[p + 1] = oh;
            if (!m_stall_tx) begin
                pr = $signed(bus.req_a[g]) * $signed(bus.req_b[g]);
                for (int k = p + 1; k <= p + LAT; k++) e_bsy[k] = 1;
                e_rsp[p + LAT] = oh;
                e_prd[p + LAT] = pr[PW-1:0];
                m_idle_from = p + LAT + 1;
            end else begin
                for (int k = p + 1; k <= p + 1 + TO; k++) e_bsy[k] = 1;
                e_err[p + 2 + TO] = 1;
                m_idle_from = p + 2 + TO;
            end
        end
    endtask

    task automatic step();
        int pr;
        @(negedge clk);
        cyc++;
        model_step(cyc - 1);

        chk("req_ready", bus.req_ready, e_rdy[cyc]);
        chk("rsp_valid", bus.rsp_valid, e_rsp[cyc]);
        chk("mul_Request", bus.mul_Request, e_rdy[cyc] != '0);
        chk("busy", busy, e_bsy[cyc]);
        chk("err", err, e_err[cyc]);
        if (e_rsp[cyc] != '0) chk("rsp_product", bus.rsp_product, e_prd[cyc]);

        if (bus.rsp_valid != '0) begin
            rsp_cyc.push_back(cyc);
            rsp_idx.push_back(idx_of(bus.rsp_valid));
            rsp_prd.push_back(int'(bus.rsp_product));
        end
        if (bus.req_ready != '0) rdy_cyc.push_back(cyc);
        if (err) err_cyc.push_back(cyc);

        // Multiplier: Done low for NB+1 cycles starting after the start pulse.
        if (rst) mb_left = 0;
        if (mb_left > 0) begin
            bus.mul_Done = 1'b0;
            bus.mul_Product = PW'($urandom);
            mb_left--;
        end else begin
            bus.mul_Done = 1'b1;
            bus.mul_Product = mprod;
        end
        if (bus.mul_Request && !m_stall_tx && !rst) begin
            mb_left = NB + 1;
            pr = $signed(bus.mul_M) * $signed(bus.mul_Q);
            mprod = pr[PW-1:0];
        end

        // Requesters: drop or re-request after acceptance, randomly raise new ones.
        for (int i = 0; i < NR; i++) begin
            if (e_rdy[cyc][i]) begin
                if (auto_rand && $urandom_range(0, 1) == 1) begin
                    bus.req_a[i] = NB'($urandom);
                    bus.req_b[i] = NB'($urandom);
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end else if (auto_rand && !bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                bus.req_valid[i] = 1'b1;
                bus.req_a[i] = NB'($urandom);
                bus.req_b[i] = NB'($urandom);
            end
        end
    endtask

    task automatic set_req(input int i, input logic [NB-1:0] a, input logic [NB-1:0] b);
        bus.req_a[i] = a;
        bus.req_b[i] = b;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic clrq();
        rsp_cyc.delete(); rsp_idx.delete(); rsp_prd.delete();
        rdy_cyc.delete(); err_cyc.delete();
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int k = 0; k < budget && rsp_cyc.size() < n; k++) step();
        chk("wait_rsp", rsp_cyc.size(), n);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rsp_product"}, bus.rsp_product, 0);
        chk({tag, "_mul_M"}, bus.mul_M, 0);
        chk({tag, "_mul_Q"}, bus.mul_Q, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    endtask

    logic [NB-1:0] xa [3] = '{8'h80, 8'h7F, 8'h00};
    logic [NB-1:0] xb [3] = '{8'h80, 8'h80, 8'hFF};
    int            xp [3] = '{32'h4000, 32'hC080, 0};

    initial begin
        int s;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.mul_Done = 1'b1;
        bus.mul_Product = '0;

        // Reset state.
        step();
        check_zero("reset");
        rst = 1'b0;

        // Single request, latency and sign handling.
        clrq();
        set_req(1, 8'd5, 8'hFD);
        s = cyc;
        wait_rsp(1, 40);
        chk("t1_idx", qg(rsp_idx, 0), 1);
        chk("t1_prod", qg(rsp_prd, 0), 32'hFFF1);
        chk("t1_latency", qg(rsp_cyc, 0) - s, LAT);
        chk("t1_ready_delay", qg(rdy_cyc, 0) - s, 1);
        step();

        // All four from reset: grant order 0..3, one IDLE cycle between ops.
        rst = 1'b1;
        step();
        rst = 1'b0;
        clrq();
        for (int i = 0; i < NR; i++) set_req(i, NB'(i + 1), 8'd7);
        wait_rsp(4, 100);
        for (int k = 0; k < NR; k++) begin
            chk("t2_order", qg(rsp_idx, k), k);
            chk("t2_prod", qg(rsp_prd, k), 7 * (k + 1));
        end
        for (int k = 0; k < NR - 1; k++) chk("t2_gap", qg(rdy_cyc, k + 1) - qg(rsp_cyc, k), 2);
        step();

        // Round robin: after 2 is served, 3 beats 0.
        clrq();
        set_req(2, 8'd3, 8'd3);
        wait_rsp(1, 40);
        step();
        set_req(0, 8'd2, 8'd2);
        set_req(3, 8'd4, 8'd4);
        wait_rsp(3, 80);
        chk("t3_first", qg(rsp_idx, 1), 3);
        chk("t3_second", qg(rsp_idx, 2), 0);
        step();

        // Operand extremes.
        for (int k = 0; k < 3; k++) begin
            clrq();
            set_req(0, xa[k], xb[k]);
            wait_rsp(1, 40);
            chk("t4_extreme", qg(rsp_prd, 0), xp[k]);
            step();
        end

        // Start timeout: multiplier never drops Done.
        clrq();
        force_stall = 1'b1;
        set_req(2, 8'd9, 8'd9);
        for (int k = 0; k < 30 && err_cyc.size() == 0; k++) step();
        chk("t5_err_seen", err_cyc.size(), 1);
        chk("t5_err_delay", qg(err_cyc, 0) - qg(rdy_cyc, 0), TO + 1);
        repeat (10) step();
        chk("t5_no_rsp", rsp_cyc.size(), 0);
        force_stall = 1'b0;
        set_req(2, 8'd9, 8'hF7);
        wait_rsp(1, 40);
        chk("t5_recover", qg(rsp_prd, 0), 32'hFFAF);
        step();

        // Reset while in WAIT_DONE, then requester 0 must win over 3.
        clrq();
        set_req(1, 8'd11, 8'd11);
        repeat (5) step();
        rst = 1'b1;
        step();
        check_zero("t6");
        rst = 1'b0;
        set_req(0, 8'd6, 8'd6);
        set_req(3, 8'd5, 8'd5);
        wait_rsp(2, 60);
        chk("t6_winner", qg(rsp_idx, 0), 0);
        chk("t6_prod", qg(rsp_prd, 0), 36);
        step();

        // Randomized traffic with occasional stalled starts, then drain.
        auto_rand = 1'b1;
        repeat (1500) step();
        auto_rand = 1'b0;
        repeat (100) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
